if_fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned {pc, instruction} pairs in a DEPTH-entry FIFO so that ID-stage stalls do not stall memory.
- Accepts branch/jump redirects from the NPC logic, which flush the queue and any in-flight fetch.

---
 rtl/if_fetch_queue_if.sv | 34 +++
 rtl/if_fetch_queue.sv | 134 +++++++++++++
 tb/tb_if_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory handshake plus IF/ID head port.
// The master side is the fetch queue; the slave side is memory and IF/ID.
interface if_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one memory request
// at a time and buffers {pc, inst} pairs for IF/ID in a small FIFO.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                         clock,
    input  logic                         reset,
    if_fetch_queue_if.master             bus,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    // IDLE: nothing in flight; BUSY: request held; DROP: held but its data is stale
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DROP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            issue;
    logic            push;
    logic            pop;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     addr_q;
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    entry_t          mem_q [DEPTH];
    logic            unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];

    // A stale response (DROP) or any response in a redirect cycle is discarded.
    assign push = (state_q == S_BUSY) && bus.imem_ack && !redirect;
    assign pop  = (count_q != '0) && bus.out_ready && !redirect;

    // Request FSM: issue only when a slot is guaranteed, hold until ack.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!redirect && (count_q < CW'(DEPTH))) begin
                    state_d = S_BUSY;
                    issue   = 1'b1;
                end
            end
            S_BUSY: begin
                if (bus.imem_ack) begin
                    state_d = S_IDLE;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, held request address and fetch PC; redirect wins over the ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= PC_RESET;
            fetch_pc_q <= PC_RESET;
        end else begin
            state_q <= state_d;
            if (issue) begin
                addr_q <= fetch_pc_q;
            end
            if (redirect) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    // FIFO pointers and count; a redirect empties the queue outright.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= '{pc: addr_q, inst: bus.imem_rdata};
        end
    end

    assign bus.imem_req  = (state_q != S_IDLE);
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = mem_q[rptr_q].pc;
    assign bus.out_inst  = mem_q[rptr_q].inst;
    assign occupancy     = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, full stall, redirects,
// PC wrap and mid-operation reset, with a small latency-controlled memory.
module tb_if_fetch_queue;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;

    int n_tests;
    int n_fail;
    int lat;
    int wcnt;

    if_fetch_queue_if bus();

    if_fetch_queue #(
        .DEPTH    (4),
        .PC_RESET (32'h0000_3000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .occupancy   (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return ((a - 32'h3000) >> 2) * 32'h0001_0001 + 32'h2001_0005;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory answers after lat cycles of an asserted request.
    task automatic mem();
        #1;
        if (bus.imem_req) begin
            if (wcnt >= lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = dat(bus.imem_addr);
                wcnt           = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            wcnt         = 0;
        end
    endtask

    task automatic adv();
        @(negedge clock);
    endtask

    task automatic step();
        mem();
        adv();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        redirect     = 1'b0;
        bus.imem_ack = 1'b0;
        wcnt         = 0;
        adv();
        adv();
        reset = 1'b1;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        lat            = 0;
        wcnt           = 0;
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.out_ready  = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        // reset state
        #2 reset = 1'b0;
        @(negedge clock);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_inst", bus.out_inst, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // streaming with 1-cycle-ack memory
        bus.out_ready = 1'b1;
        mem();
        chk("c0_req", 32'(bus.imem_req), 32'd0);
        adv();
        mem();
        chk("c1_req", 32'(bus.imem_req), 32'd1);
        chk("c1_addr", bus.imem_addr, 32'h3000);
        chk("c1_valid", 32'(bus.out_valid), 32'd0);
        adv();
        mem();
        chk("c2_valid", 32'(bus.out_valid), 32'd1);
        chk("c2_pc", bus.out_pc, 32'h3000);
        chk("c2_inst", bus.out_inst, 32'h2001_0005);
        chk("c2_req", 32'(bus.imem_req), 32'd0);
        adv();
        mem();
        chk("c3_addr", bus.imem_addr, 32'h3004);
        chk("c3_valid", 32'(bus.out_valid), 32'd0);
        adv();
        mem();
        chk("c4_pc", bus.out_pc, 32'h3004);
        chk("c4_inst", bus.out_inst, 32'h2002_0006);
        adv();

        // ID stall: queue fills to DEPTH, requests stop, head holds
        bus.out_ready = 1'b0;
        run(20);
        mem();
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_req", 32'(bus.imem_req), 32'd0);
        chk("full_pc", bus.out_pc, 32'h3008);
        chk("full_inst", bus.out_inst, dat(32'h3008));
        adv();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem();
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_pc", bus.out_pc, 32'h3008 + 32'(4 * k));
            chk("drain_inst", bus.out_inst, dat(32'h3008 + 32'(4 * k)));
            adv();
        end

        // redirect while a slow request is outstanding
        do_reset();
        bus.out_ready = 1'b1;
        lat           = 0;
        run(5);
        lat         = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3043;
        mem();
        chk("rd_req", 32'(bus.imem_req), 32'd1);
        chk("rd_addr", bus.imem_addr, 32'h3008);
        adv();
        redirect = 1'b0;
        mem();
        chk("drop_req", 32'(bus.imem_req), 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h3008);
        chk("drop_occ", 32'(occupancy), 32'd0);
        adv();
        step();
        mem();
        chk("drop_ack_valid", 32'(bus.out_valid), 32'd0);
        adv();
        lat = 0;
        mem();
        chk("post_drop_req", 32'(bus.imem_req), 32'd0);
        chk("post_drop_occ", 32'(occupancy), 32'd0);
        adv();
        mem();
        chk("tgt_req", 32'(bus.imem_req), 32'd1);
        chk("tgt_addr", bus.imem_addr, 32'h3040);
        adv();
        bus.out_ready = 1'b0;
        mem();
        chk("tgt_valid", 32'(bus.out_valid), 32'd1);
        chk("tgt_pc", bus.out_pc, 32'h3040);
        chk("tgt_inst", bus.out_inst, dat(32'h3040));
        adv();

        // redirect, ack and pop all in one cycle with two entries queued
        run(2);
        redirect      = 1'b1;
        redirect_pc   = 32'h0000_5000;
        bus.out_ready = 1'b1;
        mem();
        chk("rap_occ", 32'(occupancy), 32'd2);
        chk("rap_pc", bus.out_pc, 32'h3040);
        chk("rap_addr", bus.imem_addr, 32'h3048);
        chk("rap_ack", 32'(bus.imem_ack), 32'd1);
        adv();
        redirect = 1'b0;
        mem();
        chk("rap_occ0", 32'(occupancy), 32'd0);
        chk("rap_valid0", 32'(bus.out_valid), 32'd0);
        chk("rap_req0", 32'(bus.imem_req), 32'd0);
        adv();
        mem();
        chk("rap_tgt_addr", bus.imem_addr, 32'h5000);
        adv();

        // PC wrap past 0xFFFF_FFFC
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        mem();
        chk("n5_pc", bus.out_pc, 32'h5000);
        chk("n5_inst", bus.out_inst, dat(32'h5000));
        adv();
        redirect = 1'b0;
        mem();
        chk("wr_valid0", 32'(bus.out_valid), 32'd0);
        adv();
        mem();
        chk("wr_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        adv();
        mem();
        chk("wr_pc0", bus.out_pc, 32'hFFFF_FFFC);
        chk("wr_inst0", bus.out_inst, dat(32'hFFFF_FFFC));
        adv();
        mem();
        chk("wr_addr1", bus.imem_addr, 32'h0000_0000);
        adv();
        bus.out_ready = 1'b0;
        mem();
        chk("wr_pc1", bus.out_pc, 32'h0000_0000);
        chk("wr_inst1", bus.out_inst, dat(32'h0000_0000));
        adv();

        // asynchronous reset mid-operation
        run(3);
        lat = 5;
        step();
        mem();
        chk("mid_occ", 32'(occupancy), 32'd3);
        chk("mid_req", 32'(bus.imem_req), 32'd1);
        chk("mid_addr", bus.imem_addr, 32'h0000_000C);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_pc", bus.out_pc, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        adv();
        adv();
        reset = 1'b1;
        adv();
        lat  = 0;
        wcnt = 0;
        mem();
        chk("rel_occ", 32'(occupancy), 32'd0);
        chk("rel_req", 32'(bus.imem_req), 32'd1);
        chk("rel_addr", bus.imem_addr, 32'h3000);
        adv();
        mem();
        chk("rel_pc", bus.out_pc, 32'h3000);
        chk("rel_inst", bus.out_inst, dat(32'h3000));
        adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
